// File: rtl/display_timings_gen.sv
// Runtime-programmable video timing generator.
// Produces pixel coordinates, sync, blanking, data-enable and line/frame start
// strobes from a timing set presented on input ports. The timing set is
// captured into shadow registers at reset and on the frame wrap only, so a mode
// change always takes effect on a clean frame boundary.
//
// Ports
//   clk_pix                      pixel clock
//   rst                          synchronous active-high reset (overrides ce)
//   ce                           pixel enable, one pixel per ce=1 clock
//   h_active/h_fp/h_sync/h_bp    horizontal timing, in pixels
//   v_active/v_fp/v_sync/v_bp    vertical timing, in lines
//   hs_pol, vs_pol               sync polarity, 1 = active-high
//   sx, sy                       current position
//   hsync, vsync                 syncs with polarity applied
//   hblank, vblank               outside the active region on that axis
//   de                           inside the active region on both axes
//   line_start, frame_start      sx==0, and sx==0 && sy==0
module display_timings_gen #(
    parameter int unsigned CORDW = 12
) (
    input  logic             clk_pix,
    input  logic             rst,
    input  logic             ce,
    input  logic [CORDW-1:0] h_active,
    input  logic [CORDW-1:0] h_fp,
    input  logic [CORDW-1:0] h_sync,
    input  logic [CORDW-1:0] h_bp,
    input  logic [CORDW-1:0] v_active,
    input  logic [CORDW-1:0] v_fp,
    input  logic [CORDW-1:0] v_sync,
    input  logic [CORDW-1:0] v_bp,
    input  logic             hs_pol,
    input  logic             vs_pol,
    output logic [CORDW-1:0] sx,
    output logic [CORDW-1:0] sy,
    output logic             hsync,
    output logic             vsync,
    output logic             hblank,
    output logic             vblank,
    output logic             de,
    output logic             line_start,
    output logic             frame_start
);

    // Sums of four CORDW fields need two extra bits to never overflow.
    localparam int unsigned TW = CORDW + 2;

    // Shadow copy of the timing set in use for the current frame.
    logic [CORDW-1:0] s_h_active, s_h_fp, s_h_sync, s_h_bp;
    logic [CORDW-1:0] s_v_active, s_v_fp, s_v_sync, s_v_bp;
    logic             s_hs_pol, s_vs_pol;

    logic [TW-1:0]    h_total_s, v_total_s, h_total_i, v_total_i;
    logic             h_last, v_last, wrap;
    logic [CORDW-1:0] nx_sx, nx_sy;

    // Timing set that the next position is decoded against.
    logic [CORDW-1:0] e_h_active, e_h_fp, e_h_sync;
    logic [CORDW-1:0] e_v_active, e_v_fp, e_v_sync;
    logic             e_hs_pol, e_vs_pol;

    logic [TW-1:0]    hs_beg, hs_end, vs_beg, vs_end;
    logic             nx_hblank, nx_vblank, nx_hs_on, nx_vs_on;

    // Totals from the shadow (counting) and from the ports (reset load).
    assign h_total_s = TW'(s_h_active) + TW'(s_h_fp) + TW'(s_h_sync) + TW'(s_h_bp);
    assign v_total_s = TW'(s_v_active) + TW'(s_v_fp) + TW'(s_v_sync) + TW'(s_v_bp);
    assign h_total_i = TW'(h_active) + TW'(h_fp) + TW'(h_sync) + TW'(h_bp);
    assign v_total_i = TW'(v_active) + TW'(v_fp) + TW'(v_sync) + TW'(v_bp);

    // Next-count computation.
    always_comb begin
        h_last = (TW'(sx) == h_total_s - TW'(1));
        v_last = (TW'(sy) == v_total_s - TW'(1));
        wrap   = h_last && v_last;
        nx_sx  = sx + CORDW'(1);
        nx_sy  = sy;
        if (h_last) begin
            nx_sx = '0;
            nx_sy = v_last ? '0 : sy + CORDW'(1);
        end
    end

    // On the wrap the new frame's (0,0) is decoded with the freshly captured set.
    always_comb begin
        e_h_active = wrap ? h_active : s_h_active;
        e_h_fp     = wrap ? h_fp     : s_h_fp;
        e_h_sync   = wrap ? h_sync   : s_h_sync;
        e_v_active = wrap ? v_active : s_v_active;
        e_v_fp     = wrap ? v_fp     : s_v_fp;
        e_v_sync   = wrap ? v_sync   : s_v_sync;
        e_hs_pol   = wrap ? hs_pol   : s_hs_pol;
        e_vs_pol   = wrap ? vs_pol   : s_vs_pol;
    end

    // Decode of the next position.
    always_comb begin
        hs_beg    = TW'(e_h_active) + TW'(e_h_fp);
        hs_end    = hs_beg + TW'(e_h_sync);
        vs_beg    = TW'(e_v_active) + TW'(e_v_fp);
        vs_end    = vs_beg + TW'(e_v_sync);
        nx_hblank = (TW'(nx_sx) >= TW'(e_h_active));
        nx_vblank = (TW'(nx_sy) >= TW'(e_v_active));
        nx_hs_on  = (TW'(nx_sx) >= hs_beg) && (TW'(nx_sx) < hs_end);
        nx_vs_on  = (TW'(nx_sy) >= vs_beg) && (TW'(nx_sy) < vs_end);
    end

    // Counters, shadow registers and registered outputs.
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            s_h_active  <= h_active;
            s_h_fp      <= h_fp;
            s_h_sync    <= h_sync;
            s_h_bp      <= h_bp;
            s_v_active  <= v_active;
            s_v_fp      <= v_fp;
            s_v_sync    <= v_sync;
            s_v_bp      <= v_bp;
            s_hs_pol    <= hs_pol;
            s_vs_pol    <= vs_pol;
            // Park on the last pixel so the first ce lands on (0,0).
            sx          <= CORDW'(h_total_i - TW'(1));
            sy          <= CORDW'(v_total_i - TW'(1));
            hsync       <= ~hs_pol;
            vsync       <= ~vs_pol;
            hblank      <= 1'b1;
            vblank      <= 1'b1;
            de          <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (ce) begin
            if (wrap) begin
                s_h_active <= h_active;
                s_h_fp     <= h_fp;
                s_h_sync   <= h_sync;
                s_h_bp     <= h_bp;
                s_v_active <= v_active;
                s_v_fp     <= v_fp;
                s_v_sync   <= v_sync;
                s_v_bp     <= v_bp;
                s_hs_pol   <= hs_pol;
                s_vs_pol   <= vs_pol;
            end
            sx          <= nx_sx;
            sy          <= nx_sy;
            hsync       <= nx_hs_on ~^ e_hs_pol;
            vsync       <= nx_vs_on ~^ e_vs_pol;
            hblank      <= nx_hblank;
            vblank      <= nx_vblank;
            de          <= ~(nx_hblank | nx_vblank);
            line_start  <= (nx_sx == '0);
            frame_start <= (nx_sx == '0) && (nx_sy == '0);
        end
    end

endmodule

// File: tb/tb_display_timings_gen.sv
// Directed bench for display_timings_gen: small mode, polarity, ce throttle,
// mid-frame mode change, mid-line reset and 720p horizontal timing.
module tb_display_timings_gen;

    localparam int unsigned CORDW = 12;

    logic             clk_pix = 1'b0;
    logic             rst;
    logic             ce;
    logic [CORDW-1:0] h_active, h_fp, h_sync, h_bp;
    logic [CORDW-1:0] v_active, v_fp, v_sync, v_bp;
    logic             hs_pol, vs_pol;
    logic [CORDW-1:0] sx, sy;
    logic             hsync, vsync, hblank, vblank, de, line_start, frame_start;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_pix = ~clk_pix;

    display_timings_gen #(.CORDW(CORDW)) dut (
        .clk_pix     (clk_pix),
        .rst         (rst),
        .ce          (ce),
        .h_active    (h_active),
        .h_fp        (h_fp),
        .h_sync      (h_sync),
        .h_bp        (h_bp),
        .v_active    (v_active),
        .v_fp        (v_fp),
        .v_sync      (v_sync),
        .v_bp        (v_bp),
        .hs_pol      (hs_pol),
        .vs_pol      (vs_pol),
        .sx          (sx),
        .sy          (sy),
        .hsync       (hsync),
        .vsync       (vsync),
        .hblank      (hblank),
        .vblank      (vblank),
        .de          (de),
        .line_start  (line_start),
        .frame_start (frame_start)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic set_mode(input int ha, input int hf, input int hs, input int hb,
                            input int va, input int vf, input int vs, input int vb,
                            input logic hp, input logic vp);
        h_active = CORDW'(ha); h_fp = CORDW'(hf); h_sync = CORDW'(hs); h_bp = CORDW'(hb);
        v_active = CORDW'(va); v_fp = CORDW'(vf); v_sync = CORDW'(vs); v_bp = CORDW'(vb);
        hs_pol = hp; vs_pol = vp;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Small mode (h 4/1/1/1, v 3/1/1/1): 7x6, hsync at x==5, vsync on y==4.
    // Flags packed as {hsync, vsync, hblank, vblank, de, line_start, frame_start}.
    function automatic logic [6:0] small_exp(input int x, input int y, input logic hp, input logic vp);
        logic hb, vb;
        hb = (x >= 4);
        vb = (y >= 3);
        return {(x == 5) ~^ hp, (y == 4) ~^ vp, hb, vb, ~(hb | vb), x == 0, (x == 0) && (y == 0)};
    endfunction

    // Position index p within the 42-pixel frame; index 41 also equals the reset state.
    task automatic check_small(input string tag, input int p, input logic hp, input logic vp);
        check($sformatf("%s sx p=%0d", tag, p), sx, p % 7);
        check($sformatf("%s sy p=%0d", tag, p), sy, p / 7);
        check($sformatf("%s flags p=%0d", tag, p),
              {hsync, vsync, hblank, vblank, de, line_start, frame_start},
              small_exp(p % 7, p / 7, hp, vp));
    endtask

    initial begin
        int de_cnt, hs_cnt, ls_cnt, pp, fs_first, fs_second;
        logic prev_fs;
        int ls_q[$];
        int exp_ls[9];
        int hs_first, hs_last, ls_a, ls_b;

        rst = 1'b0;
        ce  = 1'b1;
        set_mode(4, 1, 1, 1, 3, 1, 1, 1, 1'b1, 1'b1);

        // Small mode, active-high syncs, ce always on.
        do_reset();
        check("rst de", de, 0);
        check("rst hsync", hsync, 0);
        check("rst vsync", vsync, 0);
        check_small("rst", 41, 1'b1, 1'b1);
        de_cnt = 0; hs_cnt = 0; ls_cnt = 0;
        for (int k = 0; k < 42; k++) begin
            tick();
            check_small("small", k, 1'b1, 1'b1);
            de_cnt += int'(de);
            hs_cnt += int'(hsync);
            ls_cnt += int'(line_start);
        end
        check("small de per frame", de_cnt, 12);
        check("small hsync per frame", hs_cnt, 6);
        check("small lines per frame", ls_cnt, 6);
        tick();
        check("small frame period", frame_start, 1);

        // Active-low syncs.
        set_mode(4, 1, 1, 1, 3, 1, 1, 1, 1'b0, 1'b0);
        do_reset();
        check("pol0 rst hsync", hsync, 1);
        check("pol0 rst vsync", vsync, 1);
        for (int k = 0; k < 42; k++) begin
            tick();
            check_small("pol0", k, 1'b0, 1'b0);
        end

        // ce on every second clock: outputs hold on ce=0, frame spans 84 clocks.
        set_mode(4, 1, 1, 1, 3, 1, 1, 1, 1'b1, 1'b1);
        do_reset();
        pp = 41; fs_first = -1; fs_second = -1; prev_fs = 1'b0;
        for (int c = 1; c <= 86; c++) begin
            ce = (c % 2 == 1);
            tick();
            if (ce) pp = (pp + 1) % 42;
            check_small("thr", pp, 1'b1, 1'b1);
            if (frame_start && !prev_fs) begin
                if (fs_first < 0) fs_first = c;
                else if (fs_second < 0) fs_second = c;
            end
            prev_fs = frame_start;
        end
        check("thr first frame_start", fs_first, 1);
        check("thr frame period", fs_second - fs_first, 84);
        ce = 1'b1;

        // Mode change to h 8/2/2/2 at sy=1; takes effect at the next frame.
        do_reset();
        exp_ls = '{1, 8, 15, 22, 29, 36, 43, 57, 71};
        ls_q.delete();
        for (int c = 1; c <= 71; c++) begin
            tick();
            if (line_start) ls_q.push_back(c);
            if (c == 8) begin
                check("chg sy at switch", sy, 1);
                set_mode(8, 2, 2, 2, 3, 1, 1, 1, 1'b1, 1'b1);
            end
            if (c == 36) check("chg old last line sx", sx, 0);
            if (c == 42) check("chg old last pixel sx", sx, 6);
            if (c == 43) check("chg new frame_start", frame_start, 1);
            if (c == 52) check("chg new hsync off sx9", hsync, 0);
            if (c == 53) check("chg new hsync on sx10", hsync, 1);
            if (c == 53) check("chg new hblank sx10", hblank, 1);
            if (c == 56) check("chg new sx13", sx, 13);
        end
        check("chg line count", ls_q.size(), 9);
        for (int i = 0; i < 9; i++)
            check($sformatf("chg line_start %0d", i), (i < ls_q.size()) ? ls_q[i] : -1, exp_ls[i]);

        // Reset asserted mid-line at (2,1) with ce high.
        set_mode(4, 1, 1, 1, 3, 1, 1, 1, 1'b1, 1'b1);
        do_reset();
        repeat (10) tick();
        check("mrst pre sx", sx, 2);
        check("mrst pre sy", sy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst sx", sx, 6);
        check("mrst sy", sy, 5);
        check("mrst de", de, 0);
        tick();
        check("mrst restart sx", sx, 0);
        check("mrst restart sy", sy, 0);
        check("mrst restart frame_start", frame_start, 1);

        // 720p horizontal timing: h 1280/110/40/220, v 720/5/5/20.
        set_mode(1280, 110, 40, 220, 720, 5, 5, 20, 1'b1, 1'b1);
        do_reset();
        check("720 rst sx", sx, 1649);
        check("720 rst sy", sy, 749);
        hs_cnt = 0; de_cnt = 0; hs_first = -1; hs_last = -1; ls_a = -1; ls_b = -1;
        for (int c = 1; c <= 1651; c++) begin
            tick();
            if (c <= 1650) begin
                if (hsync) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = int'(sx);
                    hs_last = int'(sx);
                end
                de_cnt += int'(de);
            end
            if (line_start) begin
                if (ls_a < 0) ls_a = c;
                else if (ls_b < 0) ls_b = c;
            end
            if (c == 1) check("720 vsync line0", vsync, 0);
        end
        check("720 hsync width", hs_cnt, 40);
        check("720 hsync first sx", hs_first, 1390);
        check("720 hsync last sx", hs_last, 1429);
        check("720 de per line", de_cnt, 1280);
        check("720 line period", ls_b - ls_a, 1650);
        check("720 sy line1", sy, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
